wb_select_pipe: RTL and testbench
=================================

// Module: wb_select_pipe
// PURPOSE
//  Registered, parametrised write-back selector for the CPU WB stage. Chooses one of NUM_SRC
//  source words (ALU, MEM, PC, IH, ...) under a select code and captures it with dest/we.
//  Presents a one-cycle-latency register-file write port plus a forwarding copy.
//  Waits (stalls upstream) when the MEM source is selected before memory data is acked.
// PARAMETERS
//  DATA_W      16  width of every source word and of wb_data
//  NUM_SRC     4   number of source words on src_data (sources 0..NUM_SRC-1)
//  SEL_W       3   width of in_sel; code {SEL_W{1'b1}} is NOP; need NUM_SRC < 2**SEL_W
//  REG_AW      4   register-file address width
//  MEM_SRC     1   source index that requires mem_ack before capture
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   1              upstream offers a WB op this cycle
//  in_ready   out  1              block accepts op (transfer = in_valid & in_ready)
//  in_sel     in   SEL_W          source select / NOP code
//  in_rd      in   REG_AW         destination register
//  in_we      in   1              op writes register file
//  src_data   in   NUM_SRC*DATA_W source i at bits [i*DATA_W +: DATA_W]
//  mem_ack    in   1              MEM source word on src_data is valid this cycle
//  flush      in   1              discard accepted-but-uncommitted op
//  wb_valid   out  1              wb_* outputs hold a committed op (1-cycle pulse per op)
//  wb_we      out  1              register-file write enable (= wb_valid & captured we)
//  wb_rd      out  REG_AW         register-file write address
//  wb_data    out  DATA_W         write data; holds previous value on NOP / idle
//  fwd_data   out  DATA_W         last value actually written (wb_we=1), for forwarding
//  sel_err    out  1              sticky: illegal select (>=NUM_SRC, not NOP) seen
// BEHAVIOUR
//  Reset (async): state=IDLE; wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, fwd_data=0,
//   sel_err=0; in_ready=1 after reset release.
//  FSM IDLE:
//   - in_ready=1. On transfer with sel!=MEM_SRC or mem_ack=1: next cycle wb_valid=1,
//     wb_rd=in_rd, wb_we=in_we, wb_data=selected word (latency 1).
//   - On transfer with sel==MEM_SRC and mem_ack=0: latch rd/we, go WAIT_MEM, wb_valid=0.
//  FSM WAIT_MEM:
//   - in_ready=0 (upstream stalls). Each cycle mem_ack=1: capture src MEM_SRC word with
//     latched rd/we, wb_valid=1 next cycle, return IDLE. No timeout.
//   - flush=1 (takes priority over mem_ack same cycle): drop op, no wb_valid, go IDLE.
//  flush in IDLE: the op transferred in the same cycle is dropped (no wb_valid).
//  NOP (in_sel all ones): wb_valid=1, wb_we=0, wb_rd=in_rd, wb_data unchanged.
//  Illegal sel (NUM_SRC <= sel < NOP): treated as NOP; sel_err set, cleared only by rst.
//  in_we=1 with NOP or illegal sel: wb_we forced 0.
//  fwd_data updates to wb_data only in the cycle the capture sets wb_we=1.
//  wb_valid/wb_we are single-cycle unless a new op commits the next cycle (back-to-back
//   throughput 1 op/cycle in IDLE).
//  No arithmetic; all words passed bit-exact, no extension or truncation.
//  Reset mid-WAIT_MEM: pending op discarded, outputs return to reset values.
// TESTING
//  1 ALU pass: sel=0, src0=16'h1234, rd=3, we=1 -> next cycle wb_valid=1,
//    wb_we=1, wb_rd=3, wb_data=16'h1234, fwd_data=16'h1234.
//  2 MEM wait: sel=1, mem_ack=0 for 3 cycles then 1 with src1=16'hBEEF -> in_ready=0
//    for 3 cycles, single wb_valid pulse with wb_data=16'hBEEF the cycle after ack.
//  3 NOP hold: after case 1, sel=3'b111, we=1 -> wb_valid=1, wb_we=0,
//    wb_data stays 16'h1234.
//  4 Illegal sel=5 (NUM_SRC=4): behaves as NOP, sel_err=1 and remains 1 thereafter.
//  5 Flush in WAIT_MEM coincident with mem_ack -> no wb_valid, in_ready=1 next cycle.
//  6 Async rst pulse mid-WAIT_MEM (between edges) -> all outputs 0 immediately,
//    in_ready=1 after release, no stale write appears.

Source files
------------

// File: rtl/wb_select_pipe_if.sv
// Write-back stage bus: upstream op offer/handshake, source words,
// memory acknowledge, flush, and the registered write/forwarding port.
interface wb_select_pipe_if #(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 3,
    parameter int REG_AW  = 4
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          in_sel;
    logic [REG_AW-1:0]         in_rd;
    logic                      in_we;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      mem_ack;
    logic                      flush;
    logic                      wb_valid;
    logic                      wb_we;
    logic [REG_AW-1:0]         wb_rd;
    logic [DATA_W-1:0]         wb_data;
    logic [DATA_W-1:0]         fwd_data;
    logic                      sel_err;

    // Upstream / pipeline side that offers ops and consumes the write port
    modport master (
        output in_valid, in_sel, in_rd, in_we, src_data, mem_ack, flush,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data, fwd_data, sel_err
    );

    // The write-back selector itself
    modport slave (
        input  in_valid, in_sel, in_rd, in_we, src_data, mem_ack, flush,
        output in_ready, wb_valid, wb_we, wb_rd, wb_data, fwd_data, sel_err
    );
endinterface

// File: rtl/wb_select_pipe.sv
// Registered write-back source selector. Picks one of NUM_SRC words by
// select code, commits it one cycle later with dest/we, and stalls upstream
// while a memory-sourced op waits for mem_ack.
module wb_select_pipe #(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 3,
    parameter int REG_AW  = 4,
    parameter int MEM_SRC = 1
) (
    input  logic              clk,
    input  logic              rst,
    wb_select_pipe_if.slave   bus
);
    typedef enum logic {
        ST_IDLE,
        ST_WAIT_MEM
    } state_t;

    state_t              state_q, state_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_we_q, wb_we_d;
    logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [DATA_W-1:0]   fwd_data_q, fwd_data_d;
    logic                sel_err_q, sel_err_d;
    logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
    logic                pend_we_q, pend_we_d;

    logic [DATA_W-1:0]   src_words [NUM_SRC];
    logic [DATA_W-1:0]   sel_word;
    logic                sel_nop;
    logic                sel_legal;
    logic                sel_illegal;
    logic                sel_mem;
    logic                xfer;

    // Unpack the flat source bus into one word per source
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_words[gi] = bus.src_data[gi*DATA_W +: DATA_W];
    end

    // Decode the select code and mux out the chosen word
    always_comb begin
        sel_word    = '0;
        sel_nop     = &bus.in_sel;
        sel_legal   = ({{(32-SEL_W){1'b0}}, bus.in_sel} < 32'(NUM_SRC));
        sel_illegal = !sel_legal && !sel_nop;
        sel_mem     = (bus.in_sel == SEL_W'(MEM_SRC));
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.in_sel == SEL_W'(i)) begin
                sel_word = src_words[i];
            end
        end
    end

    // Accept only while idle; a pending memory op blocks upstream
    always_comb begin
        bus.in_ready = (state_q == ST_IDLE);
        xfer         = bus.in_valid && (state_q == ST_IDLE);
    end

    // Next-state and commit logic; wb_valid/wb_we default to a single pulse
    always_comb begin
        state_d    = state_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        fwd_data_d = fwd_data_q;
        sel_err_d  = sel_err_q;
        pend_rd_d  = pend_rd_q;
        pend_we_d  = pend_we_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (sel_illegal) begin
                        sel_err_d = 1'b1;
                    end
                    if (!bus.flush) begin
                        if (!sel_legal) begin
                            // NOP or illegal code: commit a non-writing op, data held
                            wb_valid_d = 1'b1;
                            wb_rd_d    = bus.in_rd;
                        end else if (sel_mem && !bus.mem_ack) begin
                            state_d   = ST_WAIT_MEM;
                            pend_rd_d = bus.in_rd;
                            pend_we_d = bus.in_we;
                        end else begin
                            wb_valid_d = 1'b1;
                            wb_we_d    = bus.in_we;
                            wb_rd_d    = bus.in_rd;
                            wb_data_d  = sel_word;
                            if (bus.in_we) begin
                                fwd_data_d = sel_word;
                            end
                        end
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (bus.mem_ack) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = pend_we_q;
                    wb_rd_d    = pend_rd_q;
                    wb_data_d  = src_words[MEM_SRC];
                    if (pend_we_q) begin
                        fwd_data_d = src_words[MEM_SRC];
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            fwd_data_q <= '0;
            sel_err_q  <= 1'b0;
            pend_rd_q  <= '0;
            pend_we_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            fwd_data_q <= fwd_data_d;
            sel_err_q  <= sel_err_d;
            pend_rd_q  <= pend_rd_d;
            pend_we_q  <= pend_we_d;
        end
    end

    // Drive the write port from the registers
    always_comb begin
        bus.wb_valid = wb_valid_q;
        bus.wb_we    = wb_we_q;
        bus.wb_rd    = wb_rd_q;
        bus.wb_data  = wb_data_q;
        bus.fwd_data = fwd_data_q;
        bus.sel_err  = sel_err_q;
    end
endmodule

// File: tb/tb_wb_select_pipe.sv
// Testbench for wb_select_pipe: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wb_select_pipe;
    localparam int DATA_W  = 16;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 3;
    localparam int REG_AW  = 4;
    localparam int MEM_SRC = 1;
    localparam int NOP     = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_select_pipe_if #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .REG_AW(REG_AW)) bus ();

    wb_select_pipe #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .REG_AW(REG_AW), .MEM_SRC(MEM_SRC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One op may be outstanding (waiting on memory); otherwise every accepted
    // op commits on the next edge.
    logic              m_valid, m_we, m_err, m_pend, p_we;
    logic [REG_AW-1:0] m_rd, p_rd;
    logic [DATA_W-1:0] m_data, m_fwd;

    function automatic logic [DATA_W-1:0] src_word(input int idx);
        return bus.src_data[idx*DATA_W +: DATA_W];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_we = 0; m_err = 0; m_pend = 0; p_we = 0;
            m_rd = 0; p_rd = 0; m_data = 0; m_fwd = 0;
        end else begin
            int s;
            s = int'(bus.in_sel);
            m_valid = 0;
            m_we    = 0;
            if (m_pend) begin
                if (bus.flush) begin
                    m_pend = 0;
                end else if (bus.mem_ack) begin
                    m_pend  = 0;
                    m_valid = 1;
                    m_we    = p_we;
                    m_rd    = p_rd;
                    m_data  = src_word(MEM_SRC);
                    if (p_we) m_fwd = m_data;
                end
            end else if (bus.in_valid) begin
                if (s >= NUM_SRC && s != NOP) m_err = 1;
                if (!bus.flush) begin
                    if (s >= NUM_SRC) begin
                        m_valid = 1;
                        m_rd    = bus.in_rd;
                    end else if (s == MEM_SRC && !bus.mem_ack) begin
                        m_pend = 1;
                        p_rd   = bus.in_rd;
                        p_we   = bus.in_we;
                    end else begin
                        m_valid = 1;
                        m_we    = bus.in_we;
                        m_rd    = bus.in_rd;
                        m_data  = src_word(s);
                        if (bus.in_we) m_fwd = m_data;
                    end
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        check("in_ready", 32'(bus.in_ready), 32'(!m_pend));
        check("wb_valid", 32'(bus.wb_valid), 32'(m_valid));
        check("wb_we", 32'(bus.wb_we), 32'(m_we));
        if (m_valid) check("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
        check("wb_data", 32'(bus.wb_data), 32'(m_data));
        check("fwd_data", 32'(bus.fwd_data), 32'(m_fwd));
        check("sel_err", 32'(bus.sel_err), 32'(m_err));
        if (m_valid)
            $display("commit rd=%0d we=%0b data=%h fwd=%h t=%0t", m_rd, m_we, m_data, m_fwd, $time);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input int sel, input int rd, input logic we,
                        input logic ack, input logic fl);
        bus.in_valid = v;
        bus.in_sel   = SEL_W'(sel);
        bus.in_rd    = REG_AW'(rd);
        bus.in_we    = we;
        bus.mem_ack  = ack;
        bus.flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [DATA_W-1:0] w);
        bus.src_data[idx*DATA_W +: DATA_W] = w;
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 0; bus.in_sel = '0; bus.in_rd = '0; bus.in_we = 0;
        bus.src_data = '0; bus.mem_ack = 0; bus.flush = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst wb_valid", 32'(bus.wb_valid), 32'h0);
        check("rst wb_data", 32'(bus.wb_data), 32'h0);
        check("rst sel_err", 32'(bus.sel_err), 32'h0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        check("rst in_ready", 32'(bus.in_ready), 32'h1);

        // ALU pass
        set_src(0, 16'h1234);
        step(1, 0, 3, 1, 0, 0);
        check("alu wb_valid", 32'(bus.wb_valid), 32'h1);
        check("alu wb_we", 32'(bus.wb_we), 32'h1);
        check("alu wb_rd", 32'(bus.wb_rd), 32'h3);
        check("alu wb_data", 32'(bus.wb_data), 32'h1234);
        check("alu fwd_data", 32'(bus.fwd_data), 32'h1234);

        // NOP holds data
        step(1, NOP, 5, 1, 0, 0);
        check("nop wb_valid", 32'(bus.wb_valid), 32'h1);
        check("nop wb_we", 32'(bus.wb_we), 32'h0);
        check("nop wb_rd", 32'(bus.wb_rd), 32'h5);
        check("nop wb_data", 32'(bus.wb_data), 32'h1234);

        // MEM wait: three cycles stalled, upstream keeps offering
        set_src(1, 16'hBEEF);
        step(1, 1, 6, 1, 0, 0);
        check("mem wait1 in_ready", 32'(bus.in_ready), 32'h0);
        check("mem wait1 wb_valid", 32'(bus.wb_valid), 32'h0);
        step(1, 1, 9, 0, 0, 0);
        check("mem wait2 in_ready", 32'(bus.in_ready), 32'h0);
        step(1, 1, 9, 0, 0, 0);
        check("mem wait3 in_ready", 32'(bus.in_ready), 32'h0);
        step(0, 0, 0, 0, 1, 0);
        check("mem wb_valid", 32'(bus.wb_valid), 32'h1);
        check("mem wb_rd", 32'(bus.wb_rd), 32'h6);
        check("mem wb_data", 32'(bus.wb_data), 32'hBEEF);
        check("mem fwd_data", 32'(bus.fwd_data), 32'hBEEF);
        check("mem in_ready", 32'(bus.in_ready), 32'h1);
        step(0, 0, 0, 0, 0, 0);
        check("mem pulse end", 32'(bus.wb_valid), 32'h0);

        // Illegal select behaves as NOP and sets sticky error
        step(1, 5, 2, 1, 0, 0);
        check("ill wb_valid", 32'(bus.wb_valid), 32'h1);
        check("ill wb_we", 32'(bus.wb_we), 32'h0);
        check("ill wb_data", 32'(bus.wb_data), 32'hBEEF);
        check("ill sel_err", 32'(bus.sel_err), 32'h1);
        step(0, 0, 0, 0, 0, 0);
        check("ill sel_err sticky", 32'(bus.sel_err), 32'h1);

        // Flush in WAIT_MEM wins over coincident mem_ack
        step(1, 1, 4, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("flush wb_valid", 32'(bus.wb_valid), 32'h0);
        check("flush in_ready", 32'(bus.in_ready), 32'h1);

        // Flush in IDLE drops the same-cycle op
        set_src(2, 16'h0F0F);
        step(1, 2, 7, 1, 0, 1);
        check("idle flush wb_valid", 32'(bus.wb_valid), 32'h0);
        check("idle flush fwd", 32'(bus.fwd_data), 32'hBEEF);

        // Asynchronous reset mid-WAIT_MEM, asserted between edges
        step(1, 1, 8, 1, 0, 0);
        bus.in_valid = 0; bus.mem_ack = 1;
        #2 rst = 1'b1;
        #1;
        check("arst wb_data", 32'(bus.wb_data), 32'h0);
        check("arst fwd_data", 32'(bus.fwd_data), 32'h0);
        check("arst sel_err", 32'(bus.sel_err), 32'h0);
        check("arst in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 0, 0, 0, 1, 0);
        check("arst no stale", 32'(bus.wb_valid), 32'h0);
        step(0, 0, 0, 0, 1, 0);
        check("arst in_ready after", 32'(bus.in_ready), 32'h1);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 1500; i++) begin
            bus.src_data = {$urandom, $urandom};
            if (i == 700) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
        end
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
